// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared pattern mode encodings and default 640x480 timing
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_CHECK = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

endpackage

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - hc/vc raster counters with registered sync, de and coordinates
module vga_timing_core #(
  parameter int   H_VIS  = 640,
  parameter int   H_FP   = 16,
  parameter int   H_SYNC = 96,
  parameter int   H_BP   = 48,
  parameter int   V_VIS  = 480,
  parameter int   V_FP   = 10,
  parameter int   V_SYNC = 2,
  parameter int   V_BP   = 33,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int   XW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [XW-1:0] o_hc,
  output logic [XW-1:0] o_vc,
  output logic          o_vis,
  output logic          o_frame_end,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [XW-1:0] o_pixelx,
  output logic [XW-1:0] o_pixely
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  logic [XW-1:0] r_hc;
  logic [XW-1:0] r_vc;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [XW-1:0] r_pixelx;
  logic [XW-1:0] r_pixely;

  logic w_line_end;
  logic w_frame_end;
  logic w_hs_act;
  logic w_vs_act;
  logic w_vis;

  assign w_line_end  = (r_hc == XW'(H_TOT - 1));
  assign w_frame_end = w_line_end && (r_vc == XW'(V_TOT - 1));
  assign w_hs_act    = (r_hc >= XW'(H_VIS + H_FP)) && (r_hc < XW'(H_VIS + H_FP + H_SYNC));
  assign w_vs_act    = (r_vc >= XW'(V_VIS + V_FP)) && (r_vc < XW'(V_VIS + V_FP + V_SYNC));
  assign w_vis       = (r_hc < XW'(H_VIS)) && (r_vc < XW'(V_VIS));

  // Outputs capture the decode of the position being left, so they trail hc/vc by one advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hc     <= '0;
      r_vc     <= '0;
      r_hsync  <= ~HS_POL;
      r_vsync  <= ~VS_POL;
      r_de     <= 1'b0;
      r_pixelx <= '0;
      r_pixely <= '0;
    end else if (i_en) begin
      r_hc <= w_line_end ? '0 : r_hc + XW'(1);
      if (w_line_end) begin
        r_vc <= w_frame_end ? '0 : r_vc + XW'(1);
      end
      r_hsync  <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync  <= w_vs_act ? VS_POL : ~VS_POL;
      r_de     <= w_vis;
      r_pixelx <= r_hc;
      r_pixely <= r_vc;
    end
  end

  assign o_hc        = r_hc;
  assign o_vc        = r_vc;
  assign o_vis       = w_vis;
  assign o_frame_end = w_frame_end;
  assign o_hsync     = r_hsync;
  assign o_vsync     = r_vsync;
  assign o_de        = r_de;
  assign o_pixelx    = r_pixelx;
  assign o_pixely    = r_pixely;

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test-pattern source: frame-locked mode latch, pattern mux, frame counter
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int   H_VIS     = DEF_H_VIS,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_VIS     = DEF_V_VIS,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   XW        = 11,
  parameter int   COLOR_W   = 4,
  parameter int   FRAME_W   = 8,
  parameter int   CHK_BIT   = 4,
  parameter int   BAR_SHIFT = 6,
  parameter int   GRAD_LSB  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [1:0]           i_mode,
  input  logic [3*COLOR_W-1:0] i_solid_rgb,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_de,
  output logic [XW-1:0]        o_pixelx,
  output logic [XW-1:0]        o_pixely,
  output logic [3*COLOR_W-1:0] o_rgb,
  output logic                 o_frame_start,
  output logic [FRAME_W-1:0]   o_frame_count
);

  logic [XW-1:0]        w_hc;
  logic [XW-1:0]        w_vc;
  logic                 w_vis;
  logic                 w_frame_end;
  logic [2:0]           w_bar;
  logic [3*COLOR_W-1:0] w_pix;

  mode_e                r_mode_q;
  logic [3*COLOR_W-1:0] r_rgb;
  logic                 r_frame_start;
  logic [FRAME_W-1:0]   r_frame_count;

  vga_timing_core #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP),
    .HS_POL (HS_POL),
    .VS_POL (VS_POL),
    .XW     (XW)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .o_hc        (w_hc),
    .o_vc        (w_vc),
    .o_vis       (w_vis),
    .o_frame_end (w_frame_end),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_de        (o_de),
    .o_pixelx    (o_pixelx),
    .o_pixely    (o_pixely)
  );

  assign w_bar = w_hc[BAR_SHIFT +: 3];

  always_comb begin
    w_pix = '0;
    case (r_mode_q)
      MODE_CHECK: if (w_hc[CHK_BIT] ^ w_vc[CHK_BIT]) w_pix = '1;
      MODE_BARS:  w_pix = {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}};
      MODE_GRAD:  w_pix = {w_hc[GRAD_LSB +: COLOR_W], w_vc[GRAD_LSB +: COLOR_W], {COLOR_W{1'b0}}};
      MODE_SOLID: w_pix = i_solid_rgb;
      default:    w_pix = '0;
    endcase
    if (!w_vis) w_pix = '0;
  end

  // Mode only changes on the last-pixel advance, so a frame is always drawn in one pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q      <= MODE_CHECK;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else if (i_en) begin
      r_rgb         <= w_pix;
      r_frame_start <= (w_hc == '0) && (w_vc == '0);
      if (w_frame_end) begin
        r_mode_q      <= mode_e'(i_mode);
        r_frame_count <= r_frame_count + FRAME_W'(1);
      end
    end
  end

  assign o_rgb         = r_rgb;
  assign o_frame_start = r_frame_start;
  assign o_frame_count = r_frame_count;

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  H_VIS 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48, horizontal porch and sync widths.
  V_VIS 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33, vertical porch and sync widths.
  HS_POL 0, VS_POL 0: sync active level (0 = active-low).
  XW 11, coordinate width; COLOR_W 4, bits per channel; FRAME_W 8, frame counter width.
  CHK_BIT 4, checker square size = 2^CHK_BIT; BAR_SHIFT 6, colour-bar width = 2^BAR_SHIFT; GRAD_LSB 2, gradient LSB.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  pixel-domain clock.
  rst  in  1  asynchronous, active-high reset.
  en  in  1  pixel advance enable.
  mode  in  2  pattern select.
  solid_rgb  in  3*COLOR_W  colour for solid mode, packed {R,G,B}.
  hsync  out  1  horizontal sync.
  vsync  out  1  vertical sync.
  de  out  1  display enable, visible area.
  pixelx  out  XW  current column.
  pixely  out  XW  current row.
  rgb  out  3*COLOR_W  pixel colour {R,G,B}.
  frame_start  out  1  one-cycle pulse at pixel (0,0).
  frame_count  out  FRAME_W  completed-frame count.

Function
REQ-003 H_TOT = H_VIS+H_FP+H_SYNC+H_BP; V_TOT likewise; both SHALL fit in XW bits.
REQ-004 Internal counters hc, vc SHALL advance only on cycles with en=1; with en=0 all state and outputs SHALL hold.
REQ-005 hc SHALL count 0..H_TOT-1 and then wrap to 0; on each hc wrap, vc SHALL increment, wrapping V_TOT-1 -> 0.
REQ-006 All outputs SHALL be registered and decoded from the same (hc,vc), giving one en-cycle latency; pixelx/pixely/hsync/vsync/de/rgb SHALL be mutually aligned.
REQ-007 hsync SHALL be at level HS_POL iff H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC, and at the inverse level otherwise; vsync SHALL follow the same rule on vc with V_* and VS_POL.
REQ-008 de SHALL be 1 iff hc<H_VIS and vc<V_VIS; pixelx=hc and pixely=vc at all times, including blanking.
REQ-009 rgb SHALL be all-zero whenever de=0.
REQ-010 Mode 0, checker: each channel SHALL be all-ones if x[CHK_BIT]^y[CHK_BIT], else zero.
REQ-011 Mode 1, colour bars: with b=(x>>BAR_SHIFT)[2:0], R/G/B SHALL be full-scale per b[2]/b[1]/b[0].
REQ-012 Mode 2, gradient: R=x[GRAD_LSB+COLOR_W-1:GRAD_LSB], G=y[same slice], B=0.
REQ-013 Mode 3, solid: rgb SHALL equal solid_rgb, sampled every cycle.
REQ-014 mode SHALL be latched into mode_q only on the advancing cycle where hc=H_TOT-1 and vc=V_TOT-1; pattern changes SHALL therefore take effect only at frame boundaries, never mid-frame.
REQ-015 On that same wrap, frame_count SHALL increment modulo 2^FRAME_W, and frame_start SHALL be 1 for exactly the one en-cycle in which outputs show (0,0).
REQ-016 If en drops while frame_start=1, frame_start SHALL hold 1 until the next advance, with no double count.

Reset
REQ-017 rst SHALL asynchronously set hc=vc=0, mode_q=0, frame_count=0, de=0, rgb=0, pixelx=pixely=0, frame_start=0, and hsync/vsync to their inactive levels.
REQ-018 The first advancing cycle after rst deasserts SHALL present (0,0) with frame_start=1, and frame_count SHALL remain 0.
REQ-019 rst asserted mid-frame SHALL abort the frame immediately, with no partial sync pulse extension.

Structure
REQ-020 Mode encodings (MODE_CHECK=0, MODE_BARS=1, MODE_GRAD=2, MODE_SOLID=3) and 640x480 default timing constants SHALL live in shared package vga_pkg.
REQ-021 The hc/vc counters, sync and de decode SHALL be a sub-module vga_timing_core; vga_pattern_gen SHALL add mode latch, pattern mux, and frame logic.

Verification
REQ-022 Defaults, en=1, run 1 frame: expect 800 clk per line, 525 lines, hsync low 96 clk starting at pixelx=656, vsync low for lines 490-491, and de high for 640x480=307200 cycles.
REQ-023 mode=0, CHK_BIT=4: expect rgb=0x000 at (0,0), 0xFFF at (16,0), 0x000 at (16,16), and rgb=0 at (700,10).
REQ-024 Change mode 0->1 at line 100: expect rest of frame still checker; next frame bars, with (64,0)=0x00F and (448,0)=0xFFF.
REQ-025 en pulsed 1-in-3: expect line period 2400 clk and outputs constant on en=0 cycles.
REQ-026 Run 256 frames: expect frame_count to wrap 255->0 and exactly 256 frame_start pulses.
REQ-027 Assert rst at (300,200) for 3 cycles: expect all outputs at reset values immediately, then (0,0) with frame_start=1 and frame_count=0 on the first en cycle after release.
